// File: rtl/host_uart_packet_tx.sv
// host_uart_packet_tx: serializes a latched packet of up to 32 bytes onto a UART TX line as 8N1 frames
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset
//   packet_data : packet bytes, byte k at [8k+7:8k], sent LSB byte first
//   packet_len  : byte count, legal 1..32
//   start       : request strobe
//   tx          : serial line, idles high
//   busy        : packet in flight
//   done        : one-cycle pulse after the last stop bit
//   error       : one-cycle pulse for an illegal length or a start while busy
module host_uart_packet_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] packet_data,
    input  logic [5:0]   packet_len,
    input  logic         start,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic         error
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
    state_t         state_q;
    logic [BW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [4:0]     byte_q;
    logic [255:0]   data_q;
    logic [5:0]     len_q;
    logic           tx_q;
    logic           busy_q;
    logic           done_q;
    logic           error_q;
    logic           baud_end;
    logic           len_ok;
    logic           last_byte;
    assign baud_end  = baud_q == BW'(CLKS_PER_BIT - 1);
    assign len_ok    = packet_len != 6'd0 && packet_len <= 6'd32;
    assign last_byte = byte_q == 5'(len_q - 6'd1);
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            len_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                // DONE behaves like IDLE so a start in the done cycle chains directly
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start && len_ok) begin
                        state_q <= START;
                        data_q  <= packet_data;
                        len_q   <= packet_len;
                        byte_q  <= '0;
                        bit_q   <= '0;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (start) begin
                        error_q <= 1'b1;
                    end
                end
                default: begin
                    // a start landing on the final stop edge is dropped so done and error never coincide
                    error_q <= start && !(state_q == STOP && baud_end && last_byte);
                    baud_q  <= baud_end ? '0 : baud_q + 1'b1;
                    if (baud_end) begin
                        case (state_q)
                            START: begin
                                state_q <= DATA;
                                bit_q   <= '0;
                                tx_q    <= data_q[0];
                            end
                            DATA: begin
                                if (bit_q == 3'd7) begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end else begin
                                    bit_q <= bit_q + 3'd1;
                                    tx_q  <= data_q[3'(bit_q + 3'd1)];
                                end
                            end
                            STOP: begin
                                if (last_byte) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    tx_q    <= 1'b1;
                                end else begin
                                    // shift so the current byte is always data_q[7:0]
                                    state_q <= START;
                                    byte_q  <= byte_q + 5'd1;
                                    data_q  <= data_q >> 8;
                                    tx_q    <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_host_uart_packet_tx.sv
// tb_host_uart_packet_tx: directed self-checking bench for host_uart_packet_tx
module tb_host_uart_packet_tx;
    localparam int C = 4;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] packet_data = '0;
    logic [5:0]   packet_len = '0;
    logic         start = 1'b0;
    logic         tx;
    logic         busy;
    logic         done;
    logic         error;
    int           n_checks = 0;
    int           n_fail = 0;
    always #5 clk = ~clk;
    host_uart_packet_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .reset(reset),
        .packet_data(packet_data),
        .packet_len(packet_len),
        .start(start),
        .tx(tx),
        .busy(busy),
        .done(done),
        .error(error)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // Launch a packet and check every cycle of the frame against the 8N1 framing.
    // poke: cycle at which packet_data is scrambled; ovl: cycle at which an overlapping start is issued.
    task automatic run_packet(input string tag, input int len, input logic [255:0] data, input int poke, input int ovl);
        logic [7:0] b;
        logic       e;
        packet_data = data;
        packet_len  = 6'(len);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 10 * len * C; c++) begin
            int idx = (c - 1) / C;
            b = data[(idx / 10) * 8 +: 8];
            e = (idx % 10 == 0) ? 1'b0 : (idx % 10 == 9) ? 1'b1 : b[idx % 10 - 1];
            check({tag, "_tx"}, tx, e);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_err"}, error, c == ovl + 1);
            check({tag, "_done_early"}, done, 0);
            if (c == poke) packet_data = ~packet_data;
            if (c == ovl) start = 1'b1;
            tick;
            start = 1'b0;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_done_tx"}, tx, 1);
        check({tag, "_done_err"}, error, 0);
    endtask
    initial begin
        // 1. reset values
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", error, 0);
            tick;
        end
        // 2. single byte A5
        run_packet("a5", 1, 256'hA5, -1, -1);
        tick;
        check("a5_done_clr", done, 0);
        // 3. four bytes, data scrambled mid-transfer
        run_packet("multi", 4, 256'h04030201, 20, -1);
        tick;
        tick;
        // 4. illegal lengths
        packet_len = 6'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("len0_err", error, 1);
        check("len0_busy", busy, 0);
        check("len0_tx", tx, 1);
        tick;
        check("len0_err_clr", error, 0);
        check("len0_busy2", busy, 0);
        packet_len = 6'd33;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("len33_err", error, 1);
        check("len33_busy", busy, 0);
        check("len33_tx", tx, 1);
        tick;
        check("len33_err_clr", error, 0);
        check("len33_tx2", tx, 1);
        // 5. overlap during byte 1, then chain a packet in the done cycle
        run_packet("ovl", 2, 256'hBEEF, -1, 50);
        run_packet("chain", 1, 256'h81, -1, -1);
        tick;
        check("chain_done_clr", done, 0);
        check("chain_idle_busy", busy, 0);
        // 6. reset in the data bits of byte 0
        packet_data = 256'hFF00;
        packet_len = 6'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        check("mid_tx_pre", tx, 0);
        reset = 1'b1;
        #1;
        check("mid_tx_async", tx, 1);
        check("mid_busy", busy, 0);
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("mid_no_done", done, 0);
            check("mid_idle_tx", tx, 1);
            tick;
        end
        run_packet("x3c", 1, 256'h3C, -1, -1);
        tick;
        check("x3c_done_clr", done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
